mc_sequencer: RTL and testbench

Instruction sequencer and register holder for the 8-bit microcomputer. It fetches instructions from a 256×8 synchronous memory and decodes them. It issues one-hot operation strobes to the datapath ALU, which receives AC/DR/E from this block and returns the result. The block owns PC, AR, IR, DR, AC and E, and is the control end of the ALU's AND/ADD/LDA/CMA/CIR/CIL strobe interface.

---
 rtl/mc_pkg.sv | 54 +++++
 rtl/mc_opcode_decode.sv | 45 ++++
 rtl/mc_sequencer.sv | 191 +++++++++++++++++++
 tb/tb_mc_sequencer.sv | 318 +++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/mc_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | Module   : mc_pkg                                                    |
// | Brief    : Shared opcodes, strobe indices, sequencer state encoding  |
// |            and the memory-reference classifier for mc_sequencer.     |
// | Revision : 1.0  initial release                                      |
// +----------------------------------------------------------------------+
package mc_pkg;

   localparam int DATA_W = 8;
   localparam int ADDR_W = 8;

   // Opcode field IR[7:4]
   localparam logic [3:0] OP_NOP = 4'h0;
   localparam logic [3:0] OP_AND = 4'h1;
   localparam logic [3:0] OP_ADD = 4'h2;
   localparam logic [3:0] OP_LDA = 4'h3;
   localparam logic [3:0] OP_STA = 4'h4;
   localparam logic [3:0] OP_BUN = 4'h5;
   localparam logic [3:0] OP_CMA = 4'h9;
   localparam logic [3:0] OP_CIR = 4'hA;
   localparam logic [3:0] OP_CIL = 4'hB;
   localparam logic [3:0] OP_CLE = 4'hC;
   localparam logic [3:0] OP_HLT = 4'hF;

   // Bit positions inside the ALU strobe vector
   localparam int STB_W   = 6;
   localparam int STB_AND = 0;
   localparam int STB_ADD = 1;
   localparam int STB_LDA = 2;
   localparam int STB_CMA = 3;
   localparam int STB_CIR = 4;
   localparam int STB_CIL = 5;

   typedef enum logic [3:0] {
      ST_IDLE = 4'd0,
      ST_F0   = 4'd1,
      ST_F1   = 4'd2,
      ST_A0   = 4'd3,
      ST_A1   = 4'd4,
      ST_R0   = 4'd5,
      ST_R1   = 4'd6,
      ST_EXEC = 4'd7,
      ST_ST   = 4'd8,
      ST_HALT = 4'd9
   } state_e;

   // Memory-reference instructions (AND..BUN) carry a second operand byte
   function automatic logic is_memref(input logic [3:0] opcode);
      return (opcode >= OP_AND) && (opcode <= OP_BUN);
   endfunction

endpackage
`default_nettype wire

// File: rtl/mc_opcode_decode.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | Module   : mc_opcode_decode                                          |
// | Brief    : Combinational opcode decode: memory-reference flag, ALU   |
// |            strobe vector and HLT/CLE/BUN/STA control flags.          |
// | Revision : 1.0  initial release                                      |
// +----------------------------------------------------------------------+
module mc_opcode_decode
   import mc_pkg::*;
(
   input  logic [3:0]       opcode,
   output logic             memref,
   output logic [STB_W-1:0] stb,
   output logic             hlt,
   output logic             cle,
   output logic             bun,
   output logic             sta
);

   // Undefined opcodes fall to the default arm and decode as NOP
   always_comb begin
      memref = is_memref(opcode);
      stb    = '0;
      hlt    = 1'b0;
      cle    = 1'b0;
      bun    = 1'b0;
      sta    = 1'b0;
      case (opcode)
         OP_AND:  stb[STB_AND] = 1'b1;
         OP_ADD:  stb[STB_ADD] = 1'b1;
         OP_LDA:  stb[STB_LDA] = 1'b1;
         OP_CMA:  stb[STB_CMA] = 1'b1;
         OP_CIR:  stb[STB_CIR] = 1'b1;
         OP_CIL:  stb[STB_CIL] = 1'b1;
         OP_STA:  sta = 1'b1;
         OP_BUN:  bun = 1'b1;
         OP_CLE:  cle = 1'b1;
         OP_HLT:  hlt = 1'b1;
         OP_NOP:  ;
         default: ;
      endcase
   end

endmodule
`default_nettype wire

// File: rtl/mc_sequencer.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | Module   : mc_sequencer                                              |
// | Brief    : Instruction sequencer and register holder (PC/AR/IR/DR/   |
// |            AC/E) for the 8-bit microcomputer; drives the external    |
// |            ALU through one-hot operation strobes.                    |
// | Revision : 1.0  initial release                                      |
// +----------------------------------------------------------------------+
module mc_sequencer
   import mc_pkg::*;
(
   input  logic              clk,
   input  logic              rst,
   input  logic              start,
   output logic [ADDR_W-1:0] mem_addr,
   output logic              mem_rd,
   input  logic [DATA_W-1:0] mem_rdata,
   output logic              mem_we,
   output logic [DATA_W-1:0] mem_wdata,
   output logic              and_op,
   output logic              add_op,
   output logic              lda_op,
   output logic              cma_op,
   output logic              cir_op,
   output logic              cil_op,
   output logic [DATA_W-1:0] alu_ac,
   output logic [DATA_W-1:0] alu_dr,
   output logic              alu_e,
   output logic              alu_cin,
   input  logic [DATA_W-1:0] alu_data,
   input  logic              alu_cout,
   output logic [ADDR_W-1:0] pc,
   output logic              halted
);

   state_e            state_q, state_d;
   logic [ADDR_W-1:0] pc_q, pc_d;
   logic [ADDR_W-1:0] ar_q, ar_d;
   // Only the opcode nibble of IR is architecturally meaningful; the low
   // nibble is ignored by every instruction, so it is not stored.
   logic [3:0]        ir_q, ir_d;
   logic [DATA_W-1:0] dr_q, dr_d;
   logic [DATA_W-1:0] ac_q, ac_d;
   logic              e_q, e_d;

   logic [3:0]        w_dec_op;
   logic              w_dec_memref;
   logic [STB_W-1:0]  w_dec_stb;
   logic              w_dec_hlt;
   logic              w_dec_cle;
   logic              w_dec_bun;
   logic              w_dec_sta;
   logic [STB_W-1:0]  w_stb;

   // In F1 the opcode is still on the memory bus (IR loads on that edge),
   // so the decoder looks at mem_rdata there and at IR everywhere else.
   assign w_dec_op = (state_q == ST_F1) ? mem_rdata[7:4] : ir_q;

   mc_opcode_decode u_decode (
      .opcode (w_dec_op),
      .memref (w_dec_memref),
      .stb    (w_dec_stb),
      .hlt    (w_dec_hlt),
      .cle    (w_dec_cle),
      .bun    (w_dec_bun),
      .sta    (w_dec_sta)
   );

   // Next-state, register updates and memory/strobe outputs per state
   always_comb begin
      state_d  = state_q;
      pc_d     = pc_q;
      ar_d     = ar_q;
      ir_d     = ir_q;
      dr_d     = dr_q;
      ac_d     = ac_q;
      e_d      = e_q;
      mem_addr = pc_q;
      mem_rd   = 1'b0;
      mem_we   = 1'b0;
      w_stb    = '0;
      case (state_q)
         ST_IDLE: begin
            if (start) begin
               state_d = ST_F0;
            end
         end
         ST_F0: begin
            mem_rd  = 1'b1;
            state_d = ST_F1;
         end
         ST_F1: begin
            ir_d    = mem_rdata[7:4];
            pc_d    = pc_q + 8'd1;
            state_d = w_dec_memref ? ST_A0 : ST_EXEC;
         end
         ST_A0: begin
            mem_rd  = 1'b1;
            state_d = ST_A1;
         end
         ST_A1: begin
            ar_d = mem_rdata;
            if (w_dec_bun) begin
               pc_d    = mem_rdata;
               state_d = ST_F0;
            end else if (w_dec_sta) begin
               pc_d    = pc_q + 8'd1;
               state_d = ST_ST;
            end else begin
               pc_d    = pc_q + 8'd1;
               state_d = ST_R0;
            end
         end
         ST_R0: begin
            mem_addr = ar_q;
            mem_rd   = 1'b1;
            state_d  = ST_R1;
         end
         ST_R1: begin
            dr_d    = mem_rdata;
            state_d = ST_EXEC;
         end
         ST_EXEC: begin
            w_stb = w_dec_stb;
            // AC only takes the ALU result when an ALU operation is issued
            if (|w_dec_stb) begin
               ac_d = alu_data;
            end
            if (w_dec_stb[STB_ADD]) begin
               e_d = alu_cout;
            end else if (w_dec_stb[STB_CIR]) begin
               e_d = ac_q[0];
            end else if (w_dec_stb[STB_CIL]) begin
               e_d = ac_q[7];
            end else if (w_dec_cle) begin
               e_d = 1'b0;
            end
            state_d = w_dec_hlt ? ST_HALT : ST_F0;
         end
         ST_ST: begin
            mem_addr = ar_q;
            mem_we   = 1'b1;
            state_d  = ST_F0;
         end
         ST_HALT: begin
            state_d = ST_HALT;
         end
         default: begin
            state_d = ST_IDLE;
         end
      endcase
   end

   // State and architectural registers, synchronous reset
   always_ff @(posedge clk) begin
      if (rst) begin
         state_q <= ST_IDLE;
         pc_q    <= '0;
         ar_q    <= '0;
         ir_q    <= '0;
         dr_q    <= '0;
         ac_q    <= '0;
         e_q     <= 1'b0;
      end else begin
         state_q <= state_d;
         pc_q    <= pc_d;
         ar_q    <= ar_d;
         ir_q    <= ir_d;
         dr_q    <= dr_d;
         ac_q    <= ac_d;
         e_q     <= e_d;
      end
   end

   assign and_op    = w_stb[STB_AND];
   assign add_op    = w_stb[STB_ADD];
   assign lda_op    = w_stb[STB_LDA];
   assign cma_op    = w_stb[STB_CMA];
   assign cir_op    = w_stb[STB_CIR];
   assign cil_op    = w_stb[STB_CIL];

   assign mem_wdata = ac_q;
   assign alu_ac    = ac_q;
   assign alu_dr    = dr_q;
   assign alu_e     = e_q;
   assign alu_cin   = 1'b0;
   assign pc        = pc_q;
   assign halted    = (state_q == ST_HALT);

endmodule
`default_nettype wire

// File: tb/tb_mc_sequencer.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | Module   : tb_mc_sequencer                                           |
// | Brief    : Self-checking bench for mc_sequencer with behavioural     |
// |            memory, ALU and an instruction-level reference model.     |
// | Revision : 1.0  initial release                                      |
// +----------------------------------------------------------------------+
module tb_mc_sequencer;

   logic       clk, rst, start;
   logic [7:0] mem_addr, mem_rdata, mem_wdata, alu_ac, alu_dr, alu_data, pc;
   logic       mem_rd, mem_we, and_op, add_op, lda_op, cma_op, cir_op, cil_op;
   logic       alu_e, alu_cin, alu_cout, halted;

   int n_chk  = 0;
   int n_pass = 0;

   mc_sequencer dut (
      .clk(clk), .rst(rst), .start(start),
      .mem_addr(mem_addr), .mem_rd(mem_rd), .mem_rdata(mem_rdata),
      .mem_we(mem_we), .mem_wdata(mem_wdata),
      .and_op(and_op), .add_op(add_op), .lda_op(lda_op),
      .cma_op(cma_op), .cir_op(cir_op), .cil_op(cil_op),
      .alu_ac(alu_ac), .alu_dr(alu_dr), .alu_e(alu_e), .alu_cin(alu_cin),
      .alu_data(alu_data), .alu_cout(alu_cout), .pc(pc), .halted(halted)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Synchronous 256x8 memory with a load port used while the DUT is in reset
   logic [7:0] mem [256];
   logic       ld_en = 1'b0, clr_en = 1'b0;
   logic [7:0] ld_addr = 8'h00, ld_data = 8'h00;
   always @(posedge clk) begin
      if (clr_en) begin
         for (int i = 0; i < 256; i++) mem[i] <= 8'h00;
      end else if (ld_en) begin
         mem[ld_addr] <= ld_data;
      end else if (mem_we) begin
         mem[mem_addr] <= mem_wdata;
      end
      if (mem_rd) mem_rdata <= mem[mem_addr];
   end

   // ALU one level up; drives a garbage value when no strobe is active
   always_comb begin
      alu_data = 8'hA5;
      alu_cout = 1'b0;
      if (and_op)      alu_data = alu_ac & alu_dr;
      else if (add_op) {alu_cout, alu_data} = {1'b0, alu_ac} + {1'b0, alu_dr};
      else if (lda_op) alu_data = alu_dr;
      else if (cma_op) alu_data = ~alu_ac;
      else if (cir_op) alu_data = {alu_e, alu_ac[7:1]};
      else if (cil_op) alu_data = {alu_ac[6:0], alu_e};
   end

   // Activity monitor sampled on the falling edge
   int mon_stb = 0, mon_multi = 0, mon_we = 0, mon_x = 0, mon_add = 0, mon_n = 0;
   logic [7:0] mon_we_addr = 8'h00;
   always @(negedge clk) begin
      mon_n = $countones({and_op, add_op, lda_op, cma_op, cir_op, cil_op});
      mon_stb = mon_stb + mon_n;
      if (mon_n > 1) mon_multi++;
      if (add_op) mon_add++;
      if (mem_we) begin
         mon_we++;
         mon_we_addr = mem_addr;
      end
      if (!rst && ($isunknown({pc, mem_addr, alu_ac, alu_e}) || alu_cin !== 1'b0)) mon_x++;
   end

   // Reference memory image for the instruction-level model
   logic [7:0] ref_mem [256];

   task automatic mem_clear();
      rst = 1'b1; start = 1'b0; clr_en = 1'b1;
      @(posedge clk); #1;
      clr_en = 1'b0;
      for (int i = 0; i < 256; i++) ref_mem[i] = 8'h00;
   endtask

   task automatic poke(input logic [7:0] a, input logic [7:0] d);
      ld_addr = a; ld_data = d; ld_en = 1'b1;
      @(posedge clk); #1;
      ld_en = 1'b0;
      ref_mem[a] = d;
   endtask

   // Instruction-level model: executes whole instructions from ref_mem
   task automatic iss_run(output logic [7:0] ac, output logic e, output logic [7:0] p,
                          output int nstb, output int nsta, output int cyc);
      logic [3:0] op;
      logic [7:0] a, t;
      logic [8:0] s;
      bit done;
      ac = 0; e = 0; p = 0; nstb = 0; nsta = 0; cyc = 0; done = 0;
      for (int step = 0; step < 2000 && !done; step++) begin
         op = ref_mem[p][7:4];
         p = p + 8'd1;
         if (op >= 4'h1 && op <= 4'h5) begin
            a = ref_mem[p];
            p = p + 8'd1;
            case (op)
               4'h1: begin ac = ac & ref_mem[a]; nstb++; cyc += 7; end
               4'h2: begin s = ac + ref_mem[a]; ac = s[7:0]; e = s[8]; nstb++; cyc += 7; end
               4'h3: begin ac = ref_mem[a]; nstb++; cyc += 7; end
               4'h4: begin ref_mem[a] = ac; nsta++; cyc += 5; end
               default: begin p = a; cyc += 4; end
            endcase
         end else begin
            cyc += 3;
            case (op)
               4'h9: begin ac = ~ac; nstb++; end
               4'hA: begin t = ac; ac = {e, t[7:1]}; e = t[0]; nstb++; end
               4'hB: begin t = ac; ac = {t[6:0], e}; e = t[7]; nstb++; end
               4'hC: e = 1'b0;
               4'hF: done = 1;
               default: ;
            endcase
         end
      end
      if (!done) cyc = 100000;
   endtask

   // Release reset, start, run to HALT and compare against the model
   task automatic run_prog(input string name, input int budget, input bit hold, output int cnt);
      logic [7:0] eac, epc;
      logic ee;
      int estb, esta, ecyc, s_stb, s_we, s_multi, s_x, bad;
      iss_run(eac, ee, epc, estb, esta, ecyc);
      s_stb = mon_stb; s_we = mon_we; s_multi = mon_multi; s_x = mon_x;
      rst = 1'b0; start = 1'b1;
      @(posedge clk); #1;
      cnt = 1;
      if (!hold) start = 1'b0;
      while (halted !== 1'b1 && cnt < budget) begin
         @(posedge clk); #1;
         cnt++;
      end
      n_chk++; if (halted !== 1'b1) $display("FAIL %s_halted: got %b want 1", name, halted); else n_pass++;
      n_chk++; if (cnt != ecyc + 1) $display("FAIL %s_cycles: got %0d want %0d", name, cnt, ecyc + 1); else n_pass++;
      n_chk++; if (alu_ac !== eac) $display("FAIL %s_ac: got %h want %h", name, alu_ac, eac); else n_pass++;
      n_chk++; if (alu_e !== ee) $display("FAIL %s_e: got %b want %b", name, alu_e, ee); else n_pass++;
      n_chk++; if (pc !== epc) $display("FAIL %s_pc: got %h want %h", name, pc, epc); else n_pass++;
      n_chk++; if (mon_stb - s_stb != estb) $display("FAIL %s_strobes: got %0d want %0d", name, mon_stb - s_stb, estb); else n_pass++;
      n_chk++; if (mon_we - s_we != esta) $display("FAIL %s_writes: got %0d want %0d", name, mon_we - s_we, esta); else n_pass++;
      n_chk++; if (mon_multi != s_multi || mon_x != s_x) $display("FAIL %s_onehot_x: got %0d/%0d want 0/0", name, mon_multi - s_multi, mon_x - s_x); else n_pass++;
      bad = 0;
      for (int i = 0; i < 256; i++) if (mem[i] !== ref_mem[i]) bad++;
      n_chk++; if (bad != 0) $display("FAIL %s_memory: got %0d differing bytes want 0", name, bad); else n_pass++;
   endtask

   task automatic gen_random();
      logic [3:0] ops [12];
      logic [3:0] op;
      int p, k;
      ops = '{4'h0, 4'h1, 4'h2, 4'h3, 4'h4, 4'h5, 4'h9, 4'hA, 4'hB, 4'hC, 4'h7, 4'hE};
      mem_clear();
      for (int a = 128; a < 256; a++) poke(8'(a), 8'($urandom));
      p = 0;
      while (p < 96) begin
         op = ops[$urandom_range(0, 11)];
         poke(8'(p), {op, 4'($urandom)});
         p++;
         if (op == 4'h5) begin
            k = $urandom_range(0, 3);
            poke(8'(p), 8'(p + 1 + k));
            p = p + 1 + k;
         end else if (op >= 4'h1 && op <= 4'h4) begin
            poke(8'(p), 8'($urandom_range(128, 255)));
            p++;
         end
      end
      poke(8'(p), 8'hF0);
   endtask

   task automatic test_reset();
      rst = 1'b1; start = 1'b0;
      @(posedge clk); @(posedge clk); #1;
      n_chk++; if (pc !== 8'h00) $display("FAIL reset_pc: got %h want 00", pc); else n_pass++;
      n_chk++; if (alu_ac !== 8'h00 || alu_dr !== 8'h00) $display("FAIL reset_ac_dr: got %h/%h want 00/00", alu_ac, alu_dr); else n_pass++;
      n_chk++; if (alu_e !== 1'b0 || halted !== 1'b0) $display("FAIL reset_e_halted: got %b/%b want 0/0", alu_e, halted); else n_pass++;
      n_chk++; if ({mem_rd, mem_we, and_op, add_op, lda_op, cma_op, cir_op, cil_op, alu_cin} !== 9'b0)
         $display("FAIL reset_strobes: got %b want 0", {mem_rd, mem_we, and_op, add_op, lda_op, cma_op, cir_op, cil_op, alu_cin}); else n_pass++;
      rst = 1'b0;
      @(posedge clk); @(posedge clk); #1;
      n_chk++; if (mem_rd !== 1'b0 || pc !== 8'h00) $display("FAIL idle_hold: got rd=%b pc=%h want rd=0 pc=00", mem_rd, pc); else n_pass++;
   endtask

   task automatic test_add_carry();
      int cnt, s_add;
      mem_clear();
      poke(8'h00, 8'h31); poke(8'h01, 8'h10); poke(8'h02, 8'h21); poke(8'h03, 8'h11); poke(8'h04, 8'hF0);
      poke(8'h10, 8'h7F); poke(8'h11, 8'h81);
      s_add = mon_add;
      run_prog("add", 200, 1'b0, cnt);
      n_chk++; if (alu_ac !== 8'h00 || alu_e !== 1'b1 || pc !== 8'h05) $display("FAIL add_final: got ac=%h e=%b pc=%h want 00/1/05", alu_ac, alu_e, pc); else n_pass++;
      n_chk++; if (mon_add - s_add != 1) $display("FAIL add_strobe_len: got %0d want 1", mon_add - s_add); else n_pass++;
   endtask

   task automatic test_rotate();
      int cnt;
      mem_clear();
      poke(8'h00, 8'h31); poke(8'h01, 8'h10); poke(8'h02, 8'hA0); poke(8'h03, 8'hB0); poke(8'h04, 8'hF0);
      poke(8'h10, 8'h01);
      rst = 1'b0; start = 1'b1;
      @(posedge clk); #1;
      start = 1'b0; cnt = 0;
      while (cir_op !== 1'b1 && cnt < 40) begin @(posedge clk); #1; cnt++; end
      n_chk++; if (cir_op !== 1'b1) $display("FAIL cir_seen: got %b want 1", cir_op); else n_pass++;
      @(posedge clk); #1;
      n_chk++; if (alu_ac !== 8'h00 || alu_e !== 1'b1) $display("FAIL cir_result: got %h/%b want 00/1", alu_ac, alu_e); else n_pass++;
      cnt = 0;
      while (halted !== 1'b1 && cnt < 40) begin @(posedge clk); #1; cnt++; end
      n_chk++; if (halted !== 1'b1 || alu_ac !== 8'h01 || alu_e !== 1'b0) $display("FAIL cil_result: got %b/%h/%b want 1/01/0", halted, alu_ac, alu_e); else n_pass++;
   endtask

   task automatic test_store();
      int cnt, s_we;
      mem_clear();
      poke(8'h00, 8'h31); poke(8'h01, 8'h10); poke(8'h02, 8'h40); poke(8'h03, 8'h20); poke(8'h04, 8'hF0);
      poke(8'h10, 8'h5A);
      s_we = mon_we;
      run_prog("sta", 200, 1'b0, cnt);
      n_chk++; if (mem[8'h20] !== 8'h5A) $display("FAIL sta_mem: got %h want 5a", mem[8'h20]); else n_pass++;
      n_chk++; if (mon_we - s_we != 1 || mon_we_addr !== 8'h20) $display("FAIL sta_we: got %0d@%h want 1@20", mon_we - s_we, mon_we_addr); else n_pass++;
   endtask

   task automatic test_bun_wrap();
      int cnt;
      mem_clear();
      poke(8'h01, 8'hFE); poke(8'hFE, 8'h00); poke(8'hFF, 8'h51); poke(8'h00, 8'h51); poke(8'h51, 8'hF0);
      run_prog("bun", 200, 1'b0, cnt);
      n_chk++; if (pc !== 8'h52 || cnt != 15) $display("FAIL bun_wrap: got pc=%h cyc=%0d want 52/15", pc, cnt); else n_pass++;
   endtask

   task automatic test_undefined();
      int cnt;
      mem_clear();
      poke(8'h00, 8'h31); poke(8'h01, 8'h10); poke(8'h02, 8'h70); poke(8'h03, 8'hF0); poke(8'h10, 8'hC3);
      run_prog("undef", 200, 1'b0, cnt);
      n_chk++; if (alu_ac !== 8'hC3 || alu_e !== 1'b0 || cnt != 14) $display("FAIL undef_final: got %h/%b/%0d want c3/0/14", alu_ac, alu_e, cnt); else n_pass++;
   endtask

   task automatic test_reset_mid_st();
      int cnt, s_we;
      mem_clear();
      poke(8'h00, 8'h31); poke(8'h01, 8'h10); poke(8'h02, 8'h40); poke(8'h03, 8'h20); poke(8'h04, 8'hF0);
      poke(8'h10, 8'h5A);
      rst = 1'b0; start = 1'b1;
      @(posedge clk); #1;
      start = 1'b0; cnt = 0;
      while (mem_we !== 1'b1 && cnt < 30) begin @(posedge clk); #1; cnt++; end
      n_chk++; if (mem_we !== 1'b1 || alu_ac !== 8'h5A) $display("FAIL rst_st_reach: got we=%b ac=%h want 1/5a", mem_we, alu_ac); else n_pass++;
      rst = 1'b1;
      @(posedge clk); #1;
      s_we = mon_we;
      n_chk++; if (alu_ac !== 8'h00 || mem_we !== 1'b0 || pc !== 8'h00 || halted !== 1'b0)
         $display("FAIL rst_st_regs: got ac=%h we=%b pc=%h h=%b want 00/0/00/0", alu_ac, mem_we, pc, halted); else n_pass++;
      rst = 1'b0;
      repeat (3) begin @(posedge clk); #1; end
      n_chk++; if (mon_we != s_we || mem_rd !== 1'b0 || pc !== 8'h00) $display("FAIL rst_st_idle: got we=%0d rd=%b pc=%h want 0/0/00", mon_we - s_we, mem_rd, pc); else n_pass++;
   endtask

   task automatic test_reset_mid_r1();
      mem_clear();
      poke(8'h00, 8'h31); poke(8'h01, 8'h10); poke(8'h02, 8'h31); poke(8'h03, 8'h11); poke(8'h04, 8'hF0);
      poke(8'h10, 8'h33); poke(8'h11, 8'h77);
      rst = 1'b0; start = 1'b1;
      @(posedge clk); #1;
      start = 1'b0;
      repeat (12) begin @(posedge clk); #1; end
      n_chk++; if (alu_ac !== 8'h33 || alu_dr !== 8'h33 || mem_rd !== 1'b0) $display("FAIL rst_r1_reach: got ac=%h dr=%h rd=%b want 33/33/0", alu_ac, alu_dr, mem_rd); else n_pass++;
      rst = 1'b1;
      @(posedge clk); #1;
      rst = 1'b0;
      n_chk++; if (alu_ac !== 8'h00 || alu_dr !== 8'h00 || pc !== 8'h00 || halted !== 1'b0)
         $display("FAIL rst_r1_regs: got ac=%h dr=%h pc=%h h=%b want 00/00/00/0", alu_ac, alu_dr, pc, halted); else n_pass++;
   endtask

   task automatic test_start_ignored();
      int cnt;
      logic [7:0] pc_h;
      gen_random();
      run_prog("hold", 3000, 1'b1, cnt);
      pc_h = pc;
      repeat (4) begin @(posedge clk); #1; end
      start = 1'b0;
      n_chk++; if (halted !== 1'b1 || pc !== pc_h) $display("FAIL halt_sticky: got h=%b pc=%h want 1/%h", halted, pc, pc_h); else n_pass++;
   endtask

   task automatic test_random();
      int cnt;
      for (int r = 0; r < 6; r++) begin
         gen_random();
         run_prog($sformatf("rand%0d", r), 3000, 1'b0, cnt);
      end
   endtask

   initial begin
      rst = 1'b1; start = 1'b0;
      test_reset();
      test_add_carry();
      test_rotate();
      test_store();
      test_bun_wrap();
      test_undefined();
      test_reset_mid_st();
      test_reset_mid_r1();
      test_start_ignored();
      test_random();
      $display("%0d/%0d checks passed", n_pass, n_chk);
      $finish;
   end

endmodule
`default_nettype wire
